register_reserve: RTL and testbench

Register file plus per-register reservation scoreboard that answers the decode stage. It serves operand read ports (opr0/opr1) for the register indexes decode presents, and counts outstanding writes per register from decode's reserve requests. It asserts `reserved_o` (decode's `reserved_i`) on a RAW or counter-full hazard, and retires reservations on writeback. It sits between decode, which is the initiator, and the writeback stage.

---
 rtl/register_reserve.sv | 100 ++++++++++
 tb/tb_register_reserve.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_reserve.sv
// register_reserve
//   Register file with a per-register count of outstanding writes. It answers
//   decode with operand data and a hold request, and retires reservations on
//   writeback.
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   v_i                decode holds a valid instruction
//   r0_i, r1_i         operand indexes (r0_i is also the destination)
//   use0_i, use1_i     instruction reads r0 / r1
//   w_reserve_i        reserve destination r0_i
//   reserved_o         hazard: decode must hold
//   opr0_o, opr1_o     read data, write-first bypass from writeback
//   wb_v_i, wb_r_i,
//   wb_data_i          writeback port
//   err_o              sticky error: over-reserve or writeback with nothing pending
module register_reserve #(
  parameter int W_RD  = 4,
  parameter int W_OPR = 32,
  parameter int W_CNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i,
  input  logic [W_RD-1:0]  r0_i,
  input  logic [W_RD-1:0]  r1_i,
  input  logic             use0_i,
  input  logic             use1_i,
  input  logic             w_reserve_i,
  output logic             reserved_o,
  output logic [W_OPR-1:0] opr0_o,
  output logic [W_OPR-1:0] opr1_o,
  input  logic             wb_v_i,
  input  logic [W_RD-1:0]  wb_r_i,
  input  logic [W_OPR-1:0] wb_data_i,
  output logic             err_o
);

  localparam int NREG = 2**W_RD;
  localparam logic [W_CNT-1:0] MAX = '1;

  logic [W_OPR-1:0] regs [NREG];
  logic [W_CNT-1:0] pend [NREG];
  logic             err;

  logic             wbhit0, wbhit1;
  logic [W_CNT-1:0] epend0, epend1;
  logic [NREG-1:0]  inc_vec, dec_vec;

  // Effective pending counts already account for a writeback in flight, so the
  // hold drops in the same cycle the final write is presented.
  always_comb begin
    wbhit0 = wb_v_i && (wb_r_i == r0_i);
    wbhit1 = wb_v_i && (wb_r_i == r1_i);
    epend0 = pend[r0_i];
    epend1 = pend[r1_i];
    if (wbhit0 && pend[r0_i] != '0) epend0 = pend[r0_i] - W_CNT'(1);
    if (wbhit1 && pend[r1_i] != '0) epend1 = pend[r1_i] - W_CNT'(1);
  end

  // No dependency on w_reserve_i here, so decode cannot form a loop through us.
  assign reserved_o = v_i && ((use0_i && epend0 != '0) ||
                              (use1_i && epend1 != '0) ||
                              (epend0 == MAX));

  assign opr0_o = wbhit0 ? wb_data_i : regs[r0_i];
  assign opr1_o = wbhit1 ? wb_data_i : regs[r1_i];
  assign err_o  = err;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      inc_vec[r] = w_reserve_i && (r0_i == W_RD'(r));
      dec_vec[r] = wb_v_i && (wb_r_i == W_RD'(r)) && (pend[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
      err <= 1'b0;
    end else begin
      if (wb_v_i) regs[wb_r_i] <= wb_data_i;
      for (int r = 0; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          // Saturate rather than wrap; an over-reserve is flagged instead.
          if (pend[r] == MAX) err <= 1'b1;
          else                pend[r] <= pend[r] + W_CNT'(1);
        end else if (dec_vec[r] && !inc_vec[r]) begin
          pend[r] <= pend[r] - W_CNT'(1);
        end
      end
      if (wb_v_i && pend[wb_r_i] == '0) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_register_reserve.sv
module tb_register_reserve;

  localparam int MAXC = 3;

  logic        clk, reset;
  logic        v_i, use0_i, use1_i, w_reserve_i, wb_v_i;
  logic [3:0]  r0_i, r1_i, wb_r_i;
  logic [31:0] wb_data_i;
  logic        reserved_o, err_o;
  logic [31:0] opr0_o, opr1_o;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integer counts and a data array.
  logic [31:0] m_regs [16];
  int          m_pend [16];
  bit          m_err;

  register_reserve #(.W_RD(4), .W_OPR(32), .W_CNT(2)) dut (
    .clk(clk), .reset(reset), .v_i(v_i), .r0_i(r0_i), .r1_i(r1_i),
    .use0_i(use0_i), .use1_i(use1_i), .w_reserve_i(w_reserve_i),
    .reserved_o(reserved_o), .opr0_o(opr0_o), .opr1_o(opr1_o),
    .wb_v_i(wb_v_i), .wb_r_i(wb_r_i), .wb_data_i(wb_data_i), .err_o(err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_epend(input int r);
    int p = m_pend[r];
    if (wb_v_i && int'(wb_r_i) == r && p > 0) p = p - 1;
    return p;
  endfunction

  function automatic logic m_reserved();
    return v_i && ((use0_i && m_epend(int'(r0_i)) != 0) ||
                   (use1_i && m_epend(int'(r1_i)) != 0) ||
                   (m_epend(int'(r0_i)) == MAXC));
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] r);
    return (wb_v_i && wb_r_i == r) ? wb_data_i : m_regs[r];
  endfunction

  task automatic drive(input logic v, input logic [3:0] r0, input logic [3:0] r1,
                       input logic u0, input logic u1, input logic wres,
                       input logic wbv, input logic [3:0] wbr, input logic [31:0] wbd);
    v_i = v; r0_i = r0; r1_i = r1; use0_i = u0; use1_i = u1;
    w_reserve_i = wres; wb_v_i = wbv; wb_r_i = wbr; wb_data_i = wbd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Compare all outputs against the model, then advance one edge and update it.
  task automatic cyc(input string tag);
    int n;
    #3;
    chk({tag, ".res"}, 32'(reserved_o), 32'(m_reserved()));
    chk({tag, ".opr0"}, opr0_o, m_read(r0_i));
    chk({tag, ".opr1"}, opr1_o, m_read(r1_i));
    chk({tag, ".err"}, 32'(err_o), 32'(m_err));
    @(posedge clk);
    if (wb_v_i && m_pend[wb_r_i] == 0) m_err = 1'b1;
    for (int r = 0; r < 16; r++) begin
      n = m_pend[r];
      if (w_reserve_i && int'(r0_i) == r) n = n + 1;
      if (wb_v_i && int'(wb_r_i) == r && m_pend[r] > 0) n = n - 1;
      if (n > MAXC) begin
        n = MAXC;
        m_err = 1'b1;
      end
      m_pend[r] = n;
    end
    if (wb_v_i) m_regs[wb_r_i] = wb_data_i;
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    for (int r = 0; r < 16; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 0;
    end
    m_err = 1'b0;
    #1;
    chk("rst.err", 32'(err_o), 32'(0));
    chk("rst.res", 32'(reserved_o), 32'(0));
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] pick;
    reset = 1'b1;
    idle();
    @(posedge clk); #1;
    do_reset();

    // Reset state: every index reads zero.
    for (int i = 0; i < 16; i++) begin
      drive(0, 4'(i), 4'(15 - i), 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst.opr0", opr0_o, 32'h0);
      chk("rst.opr1", opr1_o, 32'h0);
      cyc("rst");
    end

    // Write, read back, same-cycle bypass.
    drive(0, 0, 0, 0, 0, 0, 1, 3, 32'hDEAD_BEEF);
    cyc("wr3");
    drive(0, 3, 3, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rd3.opr0", opr0_o, 32'hDEAD_BEEF);
    chk("rd3.opr1", opr1_o, 32'hDEAD_BEEF);
    cyc("rd3");
    drive(0, 3, 3, 0, 0, 0, 1, 3, 32'h1234);
    #1;
    chk("byp3.opr0", opr0_o, 32'h1234);
    chk("byp3.opr1", opr1_o, 32'h1234);
    cyc("byp3");

    do_reset();
    @(posedge clk); #1;

    // RAW on r5, released by its writeback in the same cycle.
    drive(1, 5, 0, 0, 0, 1, 0, 0, 0);
    cyc("rsv5");
    drive(1, 0, 5, 0, 1, 0, 0, 0, 0);
    #1;
    chk("raw5.res", 32'(reserved_o), 32'(1));
    cyc("raw5");
    drive(1, 0, 5, 0, 1, 0, 1, 5, 32'h55);
    #1;
    chk("wb5.res", 32'(reserved_o), 32'(0));
    chk("wb5.opr1", opr1_o, 32'h55);
    cyc("wb5");

    // r7 reserved to saturation: structural hazard.
    for (int k = 0; k < 3; k++) begin
      drive(1, 7, 0, 0, 0, 1, 0, 0, 0);
      cyc("rsv7");
    end
    drive(1, 7, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("full7.res", 32'(reserved_o), 32'(1));
    cyc("full7");
    drive(1, 7, 0, 0, 0, 0, 1, 7, 32'h77);
    #1;
    chk("wb7.res", 32'(reserved_o), 32'(0));
    use0_i = 1'b1;
    #1;
    chk("wb7u.res", 32'(reserved_o), 32'(1));
    cyc("wb7");

    // Reserve and writeback on r2 in the same cycle: count unchanged.
    drive(1, 2, 0, 0, 0, 1, 0, 0, 0);
    cyc("rsv2");
    drive(1, 2, 0, 0, 0, 1, 1, 2, 32'h22);
    cyc("both2");
    drive(1, 2, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("keep2.res", 32'(reserved_o), 32'(1));
    chk("keep2.err", 32'(err_o), 32'(0));
    cyc("keep2");
    drive(1, 2, 0, 1, 0, 0, 1, 2, 32'h23);
    #1;
    chk("one2.res", 32'(reserved_o), 32'(0));
    cyc("one2");

    // Forced reserve on full r7 (pend 2 -> 3 -> still 3).
    drive(0, 7, 0, 0, 0, 1, 0, 0, 0);
    cyc("rsv7b");
    chk("pre.err", 32'(err_o), 32'(0));
    drive(0, 7, 0, 0, 0, 1, 0, 0, 0);
    cyc("over7");
    drive(1, 7, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("sat7.res", 32'(reserved_o), 32'(1));
    chk("over7.err", 32'(err_o), 32'(1));
    cyc("sat7");

    // Writeback with nothing pending on r9.
    do_reset();
    @(posedge clk); #1;
    drive(0, 0, 9, 0, 0, 0, 1, 9, 32'h99);
    #1;
    chk("wb9.err0", 32'(err_o), 32'(0));
    cyc("wb9");
    drive(0, 0, 9, 0, 0, 0, 0, 0, 0);
    #1;
    chk("wb9.err1", 32'(err_o), 32'(1));
    chk("wb9.opr1", opr1_o, 32'h99);
    for (int k = 0; k < 3; k++) cyc("hold9");
    chk("hold9.err", 32'(err_o), 32'(1));

    // Randomized traffic against the model.
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 500; k++) begin
      drive(($urandom % 4) != 0, 4'($urandom % 8), 4'($urandom % 8),
            1'($urandom), 1'($urandom), 0, ($urandom % 2) == 0,
            4'($urandom % 8), $urandom);
      if (wb_v_i && ($urandom % 8) != 0) begin
        pick = 4'($urandom % 8);
        for (int j = 0; j < 8; j++)
          if (m_pend[(int'(pick) + j) % 8] > 0 && m_pend[wb_r_i] == 0)
            wb_r_i = 4'((int'(pick) + j) % 8);
      end
      if (v_i && !m_reserved() && ($urandom % 2) == 0) w_reserve_i = 1'b1;
      cyc("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
